// File: rtl/mixcolumn_serial.sv
// mixcolumn_serial: byte-serial AES (Inv)MixColumns feeding a 32-bit register write port; MIXCOL_INV_EN adds inv
module mixcolumn_serial #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [BITS-1:0] col_in,
`ifdef MIXCOL_INV_EN
  input  logic            inv,
`endif
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] writeData,
  output logic            writeEn
);
  if (BITS != 32) begin : g_bad_bits
    $error("mixcolumn_serial supports only BITS=32");
  end
  typedef enum logic [1:0] {IDLE, CALC, WRITE} state_t;
  state_t          state, state_n;
  logic [1:0]      cnt;
  logic [BITS-1:0] src, result, rot;
  logic [7:0]      b0, b1, b2, b3, lane;
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  // rotate the column so b0 is always the byte whose lane is being produced
  always_comb begin
    rot = cnt == 2'd0 ? src :
          cnt == 2'd1 ? {src[23:0], src[31:24]} :
          cnt == 2'd2 ? {src[15:0], src[31:16]} :
                        {src[7:0],  src[31:8]};
  end
  assign {b0, b1, b2, b3} = rot;
`ifdef MIXCOL_INV_EN
  logic inv_q;
  function automatic logic [7:0] mul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? b : 8'h00);
  endfunction
  // inverse row is 0E 0B 0D 09, forward row is 02 03 01 01
  always_comb begin
    lane = inv_q ? mul(b0, 4'hE) ^ mul(b1, 4'hB) ^ mul(b2, 4'hD) ^ mul(b3, 4'h9)
                 : xt(b0) ^ xt(b1) ^ b1 ^ b2 ^ b3;
  end
  // mode is latched with the column so it cannot change mid-transform
  always_ff @(posedge clk or posedge rst) begin
    if (rst) inv_q <= 1'b0;
    else if (state != CALC && start) inv_q <= inv;
  end
`else
  assign lane = xt(b0) ^ xt(b1) ^ b1 ^ b2 ^ b3;
`endif
  // WRITE behaves like IDLE for sampling start so columns can stream every 5 cycles
  always_comb begin
    state_n = state == CALC ? (cnt == 2'd3 ? WRITE : CALC) : (start ? CALC : IDLE);
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // datapath and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 2'd0;
      src       <= '0;
      result    <= '0;
      writeData <= '0;
      writeEn   <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy    <= state_n != IDLE;
      writeEn <= state == CALC && cnt == 2'd3;
      done    <= state == CALC && cnt == 2'd3;
      if (state != CALC && start) begin
        src <= col_in;
        cnt <= 2'd0;
      end
      if (state == CALC) begin
        result[8*(2'd3-cnt) +: 8] <= lane;
        cnt <= cnt + 2'd1;
        if (cnt == 2'd3) writeData <= {result[31:8], lane};
      end
    end
  end
endmodule

// File: tb/tb_mixcolumn_serial.sv
// tb_mixcolumn_serial: directed-vector bench for mixcolumn_serial (inverse vectors when MIXCOL_INV_EN is defined)
module tb_mixcolumn_serial;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] col_in = '0;
  logic        busy, done, writeEn;
  logic [31:0] writeData;
  int          checks = 0, failures = 0;
  int          n_we;
  logic [31:0] cap;
`ifdef MIXCOL_INV_EN
  logic        inv = 1'b0;
`endif
  mixcolumn_serial dut (
    .clk(clk), .rst(rst), .start(start), .col_in(col_in),
`ifdef MIXCOL_INV_EN
    .inv(inv),
`endif
    .busy(busy), .done(done), .writeData(writeData), .writeEn(writeEn)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic run_col(input logic [31:0] col, input logic [31:0] exp, input string tag);
    start = 1'b1;
    col_in = col;
    step();
    start = 1'b0;
    col_in = ~col;
    chk({tag, ".busy"}, {31'b0, busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk({tag, ".early_we"}, {31'b0, writeEn}, 32'd0);
    end
    step();
    chk({tag, ".we"}, {31'b0, writeEn}, 32'd1);
    chk({tag, ".done"}, {31'b0, done}, 32'd1);
    chk({tag, ".data"}, writeData, exp);
    step();
    chk({tag, ".we_end"}, {31'b0, writeEn}, 32'd0);
    chk({tag, ".idle"}, {31'b0, busy}, 32'd0);
    chk({tag, ".hold"}, writeData, exp);
  endtask
  initial begin
    start = 1'b1;
    col_in = 32'hDB135345;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst.busy", {31'b0, busy}, 32'd0);
      chk("rst.we", {31'b0, writeEn}, 32'd0);
      chk("rst.done", {31'b0, done}, 32'd0);
      chk("rst.data", writeData, 32'd0);
    end
    rst = 1'b0;
    start = 1'b0;
    step();
    chk("idle.busy", {31'b0, busy}, 32'd0);
    run_col(32'hDB135345, 32'h8E4DA1BC, "fwd1");
    run_col(32'hF20A225C, 32'h9FDC589D, "fwd2");
    run_col(32'hD4BF5D30, 32'h046681E5, "fwd3");
    run_col(32'h01010101, 32'h01010101, "fix01");
    run_col(32'hC6C6C6C6, 32'hC6C6C6C6, "fixC6");
    start = 1'b1;
    col_in = 32'hDB135345;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    col_in = 32'hF20A225C;
    step();
    start = 1'b0;
    n_we = 0;
    cap = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (writeEn) begin
        n_we++;
        cap = writeData;
      end
    end
    chk("busyrule.count", n_we, 32'd1);
    chk("busyrule.data", cap, 32'h8E4DA1BC);
    start = 1'b1;
    col_in = 32'hF20A225C;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("b2b.early_we", {31'b0, writeEn}, 32'd0);
    end
    col_in = 32'hD4BF5D30;
    step();
    chk("b2b.we1", {31'b0, writeEn}, 32'd1);
    chk("b2b.data1", writeData, 32'h9FDC589D);
    step();
    start = 1'b0;
    chk("b2b.gap_we", {31'b0, writeEn}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("b2b.mid_we", {31'b0, writeEn}, 32'd0);
    end
    step();
    chk("b2b.we2", {31'b0, writeEn}, 32'd1);
    chk("b2b.data2", writeData, 32'h046681E5);
    step();
    chk("b2b.we_end", {31'b0, writeEn}, 32'd0);
    start = 1'b1;
    col_in = 32'hDB135345;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("abort.busy", {31'b0, busy}, 32'd0);
    chk("abort.data", writeData, 32'd0);
    step();
    rst = 1'b0;
    n_we = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (writeEn) n_we++;
    end
    chk("abort.count", n_we, 32'd0);
    chk("abort.data_after", writeData, 32'd0);
    run_col(32'hD4BF5D30, 32'h046681E5, "fresh");
`ifdef MIXCOL_INV_EN
    inv = 1'b1;
    run_col(32'h8E4DA1BC, 32'hDB135345, "inv1");
    run_col(32'h9FDC589D, 32'hF20A225C, "inv2");
    inv = 1'b0;
    run_col(32'hDB135345, 32'h8E4DA1BC, "invoff");
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
